// File: rtl/pid_pkg.sv
// Shared widths, FSM encoding, config addresses and clamp helpers for the PID term sequencer.
package pid_pkg;
    localparam int DW   = 6;
    localparam int GW   = 6;
    localparam int FRAC = 2;
    localparam int IW   = 10;
    localparam int PW   = IW + GW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERR   = 3'd1,
        MUL_P = 3'd2,
        MUL_I = 3'd3,
        MUL_D = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [1:0] CFG_KP = 2'd0;
    localparam logic [1:0] CFG_KI = 2'd1;
    localparam logic [1:0] CFG_KD = 2'd2;

    // A value fits when every bit above the target sign bit matches it.
    function automatic logic signed [IW-1:0] sat_iw(input logic signed [IW:0] v);
        logic signed [IW-1:0] r;
        if (v[IW] == v[IW-1]) begin
            r = v[IW-1:0];
        end else if (v[IW]) begin
            r = {1'b1, {(IW-1){1'b0}}};
        end else begin
            r = {1'b0, {(IW-1){1'b1}}};
        end
        return r;
    endfunction

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] v);
        logic signed [DW-1:0] r;
        logic [PW-DW:0]       hi;
        hi = v[PW-1:DW-1];
        if ((&hi) || !(|hi)) begin
            r = v[DW-1:0];
        end else if (v[PW-1]) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction
endpackage

// File: rtl/pid_sat_shift.sv
// Rescales a raw gain product by the gain fraction (floor) and clamps it to a contribution.
module pid_sat_shift
    import pid_pkg::*;
(
    input  logic signed [PW-1:0] prod,
    output logic signed [DW-1:0] res
);
    logic signed [PW-1:0] shifted_s;

    // Arithmetic shift rounds toward minus infinity, then clamp.
    always_comb begin
        shifted_s = prod >>> FRAC;
        res       = sat_dw(shifted_s);
    end
endmodule

// File: rtl/pid_term_sequencer.sv
// Sequences one sample through error/integrator/derivative update and a shared gain multiplier
// to produce the P, I and D contributions.
module pid_term_sequencer
    import pid_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic signed [DW-1:0] setpoint,
    input  logic signed [DW-1:0] measure,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_addr,
    input  logic [GW-1:0]        cfg_data,
    input  logic                 int_clear,
    output logic signed [DW-1:0] p_contrib,
    output logic signed [DW-1:0] i_contrib,
    output logic signed [DW-1:0] d_contrib,
    output logic                 contrib_valid,
    output logic                 busy
);
    state_t               state_r;
    logic                 sample_ready_r;
    logic                 contrib_valid_r;
    logic signed [DW-1:0] sp_r, meas_r;
    logic [GW-1:0]        kp_r, ki_r, kd_r;
    logic [GW-1:0]        kp_snap_r, ki_snap_r, kd_snap_r;
    logic signed [DW:0]   e_r, e_prev_r;
    logic signed [DW+1:0] diff_r;
    logic signed [IW-1:0] acc_r, acc_op_r;
    logic signed [DW-1:0] pend_p_r, pend_i_r, pend_d_r;
    logic signed [DW-1:0] p_contrib_r, i_contrib_r, d_contrib_r;

    logic signed [DW:0]   e_s, e_prev_eff_s;
    logic signed [DW+1:0] diff_s;
    logic signed [IW-1:0] acc_base_s, acc_next_s;
    logic signed [IW:0]   acc_sum_s;
    logic signed [IW-1:0] op_s;
    logic [GW-1:0]        gain_s;
    logic signed [PW-1:0] prod_s;
    logic signed [DW-1:0] res_s;

    // ERR-step arithmetic; a concurrent int_clear wipes the history before it is used.
    always_comb begin
        e_s = {sp_r[DW-1], sp_r} - {meas_r[DW-1], meas_r};
        if (int_clear) begin
            e_prev_eff_s = {(DW+1){1'b0}};
            acc_base_s   = {IW{1'b0}};
        end else begin
            e_prev_eff_s = e_prev_r;
            acc_base_s   = acc_r;
        end
        diff_s     = {e_s[DW], e_s} - {e_prev_eff_s[DW], e_prev_eff_s};
        acc_sum_s  = {acc_base_s[IW-1], acc_base_s} + {{(IW-DW){e_s[DW]}}, e_s};
        acc_next_s = sat_iw(acc_sum_s);
    end

    // Operand/gain select for the single shared multiplier.
    always_comb begin
        op_s   = {IW{1'b0}};
        gain_s = {GW{1'b0}};
        case (state_r)
            MUL_P: begin
                op_s   = {{(IW-DW-1){e_r[DW]}}, e_r};
                gain_s = kp_snap_r;
            end
            MUL_I: begin
                op_s   = acc_op_r;
                gain_s = ki_snap_r;
            end
            MUL_D: begin
                op_s   = {{(IW-DW-2){diff_r[DW+1]}}, diff_r};
                gain_s = kd_snap_r;
            end
            default: begin
                op_s   = {IW{1'b0}};
                gain_s = {GW{1'b0}};
            end
        endcase
        prod_s = $signed({{(PW-IW){op_s[IW-1]}}, op_s}) * $signed({{(PW-GW){1'b0}}, gain_s});
    end

    pid_sat_shift u_sat_shift (
        .prod (prod_s),
        .res  (res_s)
    );

    // Sequencer FSM with gain registers, integrator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            sample_ready_r  <= 1'b1;
            contrib_valid_r <= 1'b0;
            sp_r            <= {DW{1'b0}};
            meas_r          <= {DW{1'b0}};
            kp_r            <= {GW{1'b0}};
            ki_r            <= {GW{1'b0}};
            kd_r            <= {GW{1'b0}};
            kp_snap_r       <= {GW{1'b0}};
            ki_snap_r       <= {GW{1'b0}};
            kd_snap_r       <= {GW{1'b0}};
            e_r             <= {(DW+1){1'b0}};
            e_prev_r        <= {(DW+1){1'b0}};
            diff_r          <= {(DW+2){1'b0}};
            acc_r           <= {IW{1'b0}};
            acc_op_r        <= {IW{1'b0}};
            pend_p_r        <= {DW{1'b0}};
            pend_i_r        <= {DW{1'b0}};
            pend_d_r        <= {DW{1'b0}};
            p_contrib_r     <= {DW{1'b0}};
            i_contrib_r     <= {DW{1'b0}};
            d_contrib_r     <= {DW{1'b0}};
        end else begin
            contrib_valid_r <= 1'b0;

            case (cfg_addr)
                CFG_KP:  if (cfg_we) kp_r <= cfg_data; else kp_r <= kp_r;
                CFG_KI:  if (cfg_we) ki_r <= cfg_data; else ki_r <= ki_r;
                CFG_KD:  if (cfg_we) kd_r <= cfg_data; else kd_r <= kd_r;
                default: kp_r <= kp_r;
            endcase

            case (state_r)
                IDLE: begin
                    if (sample_valid && sample_ready_r) begin
                        sp_r           <= setpoint;
                        meas_r         <= measure;
                        kp_snap_r      <= kp_r;
                        ki_snap_r      <= ki_r;
                        kd_snap_r      <= kd_r;
                        sample_ready_r <= 1'b0;
                        state_r        <= ERR;
                    end else begin
                        sample_ready_r <= 1'b1;
                    end
                end
                ERR: begin
                    e_r      <= e_s;
                    diff_r   <= diff_s;
                    acc_r    <= acc_next_s;
                    acc_op_r <= acc_next_s;
                    state_r  <= MUL_P;
                end
                MUL_P: begin
                    pend_p_r <= res_s;
                    state_r  <= MUL_I;
                end
                MUL_I: begin
                    pend_i_r <= res_s;
                    state_r  <= MUL_D;
                end
                MUL_D: begin
                    pend_d_r <= res_s;
                    state_r  <= DONE;
                end
                DONE: begin
                    p_contrib_r     <= pend_p_r;
                    i_contrib_r     <= pend_i_r;
                    d_contrib_r     <= pend_d_r;
                    contrib_valid_r <= 1'b1;
                    e_prev_r        <= e_r;
                    state_r         <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            // Outside ERR the clear wins over any integrator update; in ERR it was folded in above.
            if (int_clear) begin
                e_prev_r <= {(DW+1){1'b0}};
                if (state_r != ERR) begin
                    acc_r <= {IW{1'b0}};
                end
            end
        end
    end

    assign sample_ready  = sample_ready_r;
    assign busy          = ~sample_ready_r;
    assign contrib_valid = contrib_valid_r;
    assign p_contrib     = p_contrib_r;
    assign i_contrib     = i_contrib_r;
    assign d_contrib     = d_contrib_r;
endmodule

// File: tb/tb_pid_term_sequencer.sv
// Scoreboard bench for pid_term_sequencer: a behavioural model pushes expected contributions at
// accept time and a monitor pops and compares them on every contrib_valid pulse.
module tb_pid_term_sequencer;
    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic              sample_ready;
    logic signed [5:0] setpoint;
    logic signed [5:0] measure;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [5:0]        cfg_data;
    logic              int_clear;
    logic signed [5:0] p_contrib;
    logic signed [5:0] i_contrib;
    logic signed [5:0] d_contrib;
    logic              contrib_valid;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int p;
        int i;
        int d;
    } exp_t;
    exp_t sb[$];

    int m_kp, m_ki, m_kd, m_acc, m_eprev;

    always #5 clk = ~clk;

    pid_term_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .setpoint      (setpoint),
        .measure       (measure),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .int_clear     (int_clear),
        .p_contrib     (p_contrib),
        .i_contrib     (i_contrib),
        .d_contrib     (d_contrib),
        .contrib_valid (contrib_valid),
        .busy          (busy)
    );

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int mul_sat(int op, int g);
        int v;
        v = (op * g) >>> 2;
        return clampi(v, -32, 31);
    endfunction

    task automatic model_push(input int sp, input int meas);
        exp_t x;
        int   e, d;
        e       = sp - meas;
        d       = e - m_eprev;
        m_acc   = clampi(m_acc + e, -512, 511);
        x.p     = mul_sat(e, m_kp);
        x.i     = mul_sat(m_acc, m_ki);
        x.d     = mul_sat(d, m_kd);
        m_eprev = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (!rst && contrib_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got pulse, expected none (p=%0d i=%0d d=%0d)",
                         p_contrib, i_contrib, d_contrib);
            end else begin
                x = sb.pop_front();
                n_checks++;
                if ($signed(p_contrib) !== x.p) $display("FAIL p_contrib: got %0d expected %0d", p_contrib, x.p);
                else n_pass++;
                n_checks++;
                if ($signed(i_contrib) !== x.i) $display("FAIL i_contrib: got %0d expected %0d", i_contrib, x.i);
                else n_pass++;
                n_checks++;
                if ($signed(d_contrib) !== x.d) $display("FAIL d_contrib: got %0d expected %0d", d_contrib, x.d);
                else n_pass++;
            end
        end
    end

    task automatic write_gain(input logic [1:0] addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = 6'(data);
        @(negedge clk);
        cfg_we = 1'b0;
        if (addr == 2'd0) m_kp = data;
        else if (addr == 2'd1) m_ki = data;
        else if (addr == 2'd2) m_kd = data;
    endtask

    task automatic pulse_clear();
        int_clear = 1'b1;
        @(negedge clk);
        int_clear = 1'b0;
        m_acc   = 0;
        m_eprev = 0;
    endtask

    // Offers one sample, optionally writes a gain mid-flight or keeps sample_valid high while busy.
    task automatic send_sample(input int sp, input int meas, input bit hold, input bit mid_we,
                               input logic [1:0] maddr, input int mdata);
        int waitn;
        int lat;
        waitn = 0;
        while (!sample_ready && waitn < 20) begin
            @(negedge clk);
            waitn++;
        end
        if (!sample_ready) begin
            n_checks++;
            $display("FAIL ready_timeout: got ready=%0b expected 1", sample_ready);
            return;
        end
        setpoint     = 6'(sp);
        measure      = 6'(meas);
        sample_valid = 1'b1;
        model_push(sp, meas);
        @(negedge clk);
        if (!hold) sample_valid = 1'b0;
        lat = 0;
        while (lat < 12) begin
            cfg_we = (mid_we && lat == 1);
            if (mid_we && lat == 1) begin
                cfg_addr = maddr;
                cfg_data = 6'(mdata);
            end
            if (lat == 4) sample_valid = 1'b0;
            @(negedge clk);
            lat++;
            if (contrib_valid) break;
        end
        cfg_we       = 1'b0;
        sample_valid = 1'b0;
        if (mid_we) begin
            if (maddr == 2'd0) m_kp = mdata;
            else if (maddr == 2'd1) m_ki = mdata;
            else if (maddr == 2'd2) m_kd = mdata;
        end
        n_checks++;
        if (lat !== 5) $display("FAIL latency: got %0d expected 5", lat);
        else n_pass++;
        n_checks++;
        if (sample_ready !== 1'b0) $display("FAIL ready_during_pulse: got %0b expected 0", sample_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (contrib_valid !== 1'b0 || sample_ready !== 1'b1)
            $display("FAIL pulse_end: got valid=%0b ready=%0b expected valid=0 ready=1", contrib_valid, sample_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (p_contrib !== 6'sd0 || i_contrib !== 6'sd0 || d_contrib !== 6'sd0)
            $display("FAIL reset_contribs: got %0d/%0d/%0d expected 0/0/0", p_contrib, i_contrib, d_contrib);
        else n_pass++;
        n_checks++;
        if (contrib_valid !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_ctrl: got valid=%0b ready=%0b busy=%0b expected 0/1/0", contrib_valid, sample_ready, busy);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        write_gain(2'd0, 4);
        write_gain(2'd1, 4);
        write_gain(2'd2, 4);
        send_sample(10, 4, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (p_contrib !== 6'sd6 || i_contrib !== 6'sd6 || d_contrib !== 6'sd6)
            $display("FAIL basic_hold: got %0d/%0d/%0d expected 6/6/6", p_contrib, i_contrib, d_contrib);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        send_sample(10, 4, 1'b1, 1'b0, 2'd0, 0);
        n_checks++;
        if (p_contrib !== 6'sd6 || i_contrib !== 6'sd12 || d_contrib !== 6'sd0)
            $display("FAIL repeat_sample: got %0d/%0d/%0d expected 6/12/0", p_contrib, i_contrib, d_contrib);
        else n_pass++;
    endtask

    task automatic test_saturation();
        write_gain(2'd0, 63);
        send_sample(31, -32, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (p_contrib !== 6'sd31) $display("FAIL p_sat_pos: got %0d expected 31", p_contrib);
        else n_pass++;
        send_sample(-32, 31, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (p_contrib !== -6'sd32) $display("FAIL p_sat_neg: got %0d expected -32", p_contrib);
        else n_pass++;
        pulse_clear();
        write_gain(2'd1, 1);
        send_sample(0, 1, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (i_contrib !== -6'sd1) $display("FAIL i_floor: got %0d expected -1", i_contrib);
        else n_pass++;
    endtask

    task automatic test_integrator();
        write_gain(2'd1, 4);
        pulse_clear();
        for (int k = 0; k < 9; k++) send_sample(31, -32, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (i_contrib !== 6'sd31 || m_acc != 511) $display("FAIL acc_clamp: got i=%0d expected 31", i_contrib);
        else n_pass++;
        pulse_clear();
        send_sample(1, 0, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (i_contrib !== 6'sd1) $display("FAIL after_clear: got %0d expected 1", i_contrib);
        else n_pass++;
    endtask

    task automatic test_gain_write_busy();
        write_gain(2'd0, 4);
        send_sample(10, 4, 1'b0, 1'b1, 2'd0, 8);
        n_checks++;
        if (p_contrib !== 6'sd6) $display("FAIL old_kp_in_flight: got %0d expected 6", p_contrib);
        else n_pass++;
        send_sample(10, 4, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (p_contrib !== 6'sd12) $display("FAIL new_kp: got %0d expected 12", p_contrib);
        else n_pass++;
        write_gain(2'd3, 63);
        send_sample(10, 4, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (p_contrib !== 6'sd12) $display("FAIL addr3_no_effect: got %0d expected 12", p_contrib);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sequence();
        setpoint     = 6'sd20;
        measure      = 6'sd0;
        sample_valid = 1'b1;
        model_push(20, 0);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        m_kp = 0; m_ki = 0; m_kd = 0; m_acc = 0; m_eprev = 0;
        n_checks++;
        if (p_contrib !== 6'sd0 || i_contrib !== 6'sd0 || d_contrib !== 6'sd0 || contrib_valid !== 1'b0
            || sample_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_mid_seq: got p=%0d i=%0d d=%0d valid=%0b ready=%0b expected 0/0/0/0/1",
                     p_contrib, i_contrib, d_contrib, contrib_valid, sample_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        write_gain(2'd2, 4);
        send_sample(10, 4, 1'b0, 1'b0, 2'd0, 0);
        n_checks++;
        if (d_contrib !== 6'sd6 || p_contrib !== 6'sd0) $display("FAIL d_after_rst: got d=%0d p=%0d expected 6 0", d_contrib, p_contrib);
        else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        setpoint     = 6'sd0;
        measure      = 6'sd0;
        cfg_we       = 1'b0;
        cfg_addr     = 2'd0;
        cfg_data     = 6'd0;
        int_clear    = 1'b0;
        m_kp = 0; m_ki = 0; m_kd = 0; m_acc = 0; m_eprev = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_integrator();
        test_gain_write_busy();
        test_reset_mid_sequence();
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
